// File: rtl/fb_access_arbiter.sv
// Framebuffer access arbiter: serialises draw-engine (client 0) and
// scanout (client 1) accesses onto a single framebuffer port using
// round-robin arbitration, coordinate rejection and a BUSY timeout.
module fb_access_arbiter #(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       c0_req,
  input  logic       c0_wr,
  input  logic [7:0] c0_x,
  input  logic [7:0] c0_y,
  input  logic [7:0] c0_din,
  input  logic       c0_mode,
  output logic       c0_ack,
  output logic       c0_err,
  output logic [7:0] c0_rdata,
  input  logic       c1_req,
  input  logic [7:0] c1_x,
  input  logic [7:0] c1_y,
  input  logic       c1_mode,
  output logic       c1_ack,
  output logic       c1_err,
  output logic [7:0] c1_rdata,
  output logic       fb_we,
  output logic       fb_re,
  output logic [7:0] fb_xpos,
  output logic [7:0] fb_ypos,
  output logic [7:0] fb_din,
  output logic       fb_r_mode,
  input  logic       fb_w_valid,
  input  logic       fb_r_valid,
  input  logic [7:0] fb_dout,
  output logic       busy,
  output logic       grant_id
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  // Counter value seen on the last permitted BUSY cycle.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic       last_gnt;
  logic       cur_wr;
  logic [7:0] tmo_cnt;

  logic       sel;
  logic       g_wr;
  logic [7:0] g_x;
  logic [7:0] g_y;
  logic [7:0] g_din;
  logic       g_mode;
  logic       g_reject;
  logic       op_done;

  // Out-of-range window, column reads running off the bottom edge, and
  // unaligned horizontal accesses that would straddle the right edge.
  function automatic logic coord_reject(input logic wr, input logic [7:0] x,
                                        input logic [7:0] y, input logic mode);
    logic bad;
    bad = (x > 8'd127) || (y > 8'd63);
    if (!wr && mode && (y > 8'd56))
      bad = 1'b1;
    if ((x[2:0] != 3'd0) && (wr || !mode) && (x > 8'd120))
      bad = 1'b1;
    return bad;
  endfunction

  // Round-robin selection and mux of the selected client's command.
  always_comb begin
    sel      = 1'b0;
    if (c0_req && c1_req)
      sel = ~last_gnt;
    else if (!c0_req && c1_req)
      sel = 1'b1;
    g_wr     = sel ? 1'b0    : c0_wr;
    g_x      = sel ? c1_x    : c0_x;
    g_y      = sel ? c1_y    : c0_y;
    g_din    = sel ? 8'h00   : c0_din;
    g_mode   = sel ? c1_mode : c0_mode;
    g_reject = coord_reject(g_wr, g_x, g_y, g_mode);
    op_done  = cur_wr ? fb_w_valid : fb_r_valid;
  end

  // Arbiter FSM with registered framebuffer command and client responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      grant_id  <= 1'b0;
      cur_wr    <= 1'b0;
      tmo_cnt   <= 8'd0;
      busy      <= 1'b0;
      fb_we     <= 1'b0;
      fb_re     <= 1'b0;
      fb_xpos   <= 8'd0;
      fb_ypos   <= 8'd0;
      fb_din    <= 8'd0;
      fb_r_mode <= 1'b0;
      c0_ack    <= 1'b0;
      c0_err    <= 1'b0;
      c0_rdata  <= 8'd0;
      c1_ack    <= 1'b0;
      c1_err    <= 1'b0;
      c1_rdata  <= 8'd0;
    end else begin
      c0_ack <= 1'b0;
      c1_ack <= 1'b0;
      c0_err <= 1'b0;
      c1_err <= 1'b0;
      case (state)
        IDLE: begin
          if (c0_req || c1_req) begin
            grant_id  <= sel;
            last_gnt  <= sel;
            busy      <= 1'b1;
            cur_wr    <= g_wr;
            tmo_cnt   <= 8'd0;
            fb_xpos   <= g_x;
            fb_ypos   <= g_y;
            fb_din    <= g_wr ? g_din : 8'h00;
            fb_r_mode <= g_wr ? 1'b0 : g_mode;
            if (g_reject) begin
              state <= RELEASE;
              if (sel) begin
                c1_ack <= 1'b1;
                c1_err <= 1'b1;
              end else begin
                c0_ack <= 1'b1;
                c0_err <= 1'b1;
              end
            end else begin
              state <= BUSY;
              fb_we <= g_wr;
              fb_re <= ~g_wr;
            end
          end
        end
        BUSY: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (op_done || (tmo_cnt == TMO_LAST)) begin
            state <= RELEASE;
            fb_we <= 1'b0;
            fb_re <= 1'b0;
            if (grant_id) begin
              c1_ack <= 1'b1;
              c1_err <= ~op_done;
              if (op_done && !cur_wr)
                c1_rdata <= fb_dout;
            end else begin
              c0_ack <= 1'b1;
              c0_err <= ~op_done;
              if (op_done && !cur_wr)
                c0_rdata <= fb_dout;
            end
          end
        end
        RELEASE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          fb_we <= 1'b0;
          fb_re <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Randomised bench for fb_access_arbiter with a transaction-level model of
// arbitration order, coordinate rejection, timeout and read-data retention.
module tb_fb_access_arbiter;

  localparam int TMO = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       c0_req, c0_wr, c0_mode;
  logic [7:0] c0_x, c0_y, c0_din;
  logic       c0_ack, c0_err;
  logic [7:0] c0_rdata;
  logic       c1_req, c1_mode;
  logic [7:0] c1_x, c1_y;
  logic       c1_ack, c1_err;
  logic [7:0] c1_rdata;
  logic       fb_we, fb_re, fb_r_mode;
  logic [7:0] fb_xpos, fb_ypos, fb_din;
  logic       fb_w_valid, fb_r_valid;
  logic [7:0] fb_dout;
  logic       busy, grant_id;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic       m_last;
  logic [7:0] m_rd [2];

  fb_access_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .c0_req(c0_req), .c0_wr(c0_wr), .c0_x(c0_x), .c0_y(c0_y),
    .c0_din(c0_din), .c0_mode(c0_mode),
    .c0_ack(c0_ack), .c0_err(c0_err), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_x(c1_x), .c1_y(c1_y), .c1_mode(c1_mode),
    .c1_ack(c1_ack), .c1_err(c1_err), .c1_rdata(c1_rdata),
    .fb_we(fb_we), .fb_re(fb_re), .fb_xpos(fb_xpos), .fb_ypos(fb_ypos),
    .fb_din(fb_din), .fb_r_mode(fb_r_mode),
    .fb_w_valid(fb_w_valid), .fb_r_valid(fb_r_valid), .fb_dout(fb_dout),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Access legality straight from the coordinate rules.
  function automatic bit rejected(input bit wr, input int x, input int y, input bit mode);
    if (x > 127 || y > 63) return 1'b1;
    if (!wr && mode && y > 56) return 1'b1;
    if ((x % 8 != 0) && (wr || !mode) && x > 120) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_c0(input bit wr, input int x, input int y, input int din, input bit mode);
    c0_req = 1'b1; c0_wr = wr; c0_x = 8'(x); c0_y = 8'(y);
    c0_din = 8'(din); c0_mode = mode;
  endtask

  task automatic set_c1(input int x, input int y, input bit mode);
    c1_req = 1'b1; c1_x = 8'(x); c1_y = 8'(y); c1_mode = mode;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_we"}, 32'(fb_we), 32'd0);
    check_eq({tag, "_re"}, 32'(fb_re), 32'd0);
    check_eq({tag, "_ack"}, 32'({c1_ack, c0_ack}), 32'd0);
  endtask

  // Serve one transaction starting from IDLE (called at a falling edge).
  // vcyc: BUSY cycle on which the framebuffer reports completion.
  task automatic serve_one(input int vcyc, input logic [7:0] dval, input bit drop_early);
    bit g, wr, mode, rej, tmo, done;
    int x, y, din, k;
    if (c0_req && c1_req) g = !m_last;
    else g = c1_req;
    if (!g) begin
      wr = c0_wr; x = int'(c0_x); y = int'(c0_y); din = int'(c0_din); mode = c0_mode;
    end else begin
      wr = 1'b0; x = int'(c1_x); y = int'(c1_y); din = 0; mode = c1_mode;
    end
    rej = rejected(wr, x, y, mode);
    tmo = !rej && (vcyc > TMO);
    @(negedge clk);
    check_eq("grant_busy", 32'(busy), 32'd1);
    check_eq("grant_id", 32'(grant_id), 32'(g));
    if (!rej) begin
      k = 1;
      done = 1'b0;
      while (!done) begin
        check_eq("busy_we", 32'(fb_we), 32'(wr));
        check_eq("busy_re", 32'(fb_re), 32'(!wr));
        check_eq("busy_xpos", 32'(fb_xpos), 32'(x));
        check_eq("busy_ypos", 32'(fb_ypos), 32'(y));
        check_eq("busy_din", 32'(fb_din), wr ? 32'(din) : 32'd0);
        check_eq("busy_rmode", 32'(fb_r_mode), wr ? 32'd0 : 32'(mode));
        check_eq("busy_noack", 32'({c1_ack, c0_ack}), 32'd0);
        if (drop_early && k == 1) begin
          if (g) c1_req = 1'b0; else c0_req = 1'b0;
        end
        if (k == vcyc) begin
          if (wr) fb_w_valid = 1'b1; else fb_r_valid = 1'b1;
          fb_dout = dval;
        end
        @(negedge clk);
        if (k == vcyc || k == TMO) done = 1'b1;
        k++;
      end
      fb_w_valid = 1'b0;
      fb_r_valid = 1'b0;
      fb_dout = 8'($urandom);
    end
    if (!rej && !tmo && !wr) m_rd[g] = dval;
    check_eq("rel_ack0", 32'(c0_ack), 32'(!g));
    check_eq("rel_ack1", 32'(c1_ack), 32'(g));
    check_eq("rel_err0", 32'(c0_err), (!g && (rej || tmo)) ? 32'd1 : 32'd0);
    check_eq("rel_err1", 32'(c1_err), (g && (rej || tmo)) ? 32'd1 : 32'd0);
    check_eq("rel_we", 32'(fb_we), 32'd0);
    check_eq("rel_re", 32'(fb_re), 32'd0);
    check_eq("rel_busy", 32'(busy), 32'd1);
    check_eq("rel_rdata0", 32'(c0_rdata), 32'(m_rd[0]));
    check_eq("rel_rdata1", 32'(c1_rdata), 32'(m_rd[1]));
    if (g) c1_req = 1'b0; else c0_req = 1'b0;
    m_last = g;
    @(negedge clk);
    check_idle_outputs("gap");
    check_eq("gap_rdata0", 32'(c0_rdata), 32'(m_rd[0]));
    check_eq("gap_rdata1", 32'(c1_rdata), 32'(m_rd[1]));
  endtask

  task automatic serve_all();
    while (c0_req || c1_req)
      serve_one(($urandom_range(0, 9) == 0) ? 40 : int'($urandom_range(1, 5)),
                8'($urandom), ($urandom_range(0, 4) == 0));
  endtask

  task automatic check_reset_state(input string tag);
    check_idle_outputs(tag);
    check_eq({tag, "_err"}, 32'({c1_err, c0_err}), 32'd0);
    check_eq({tag, "_pos"}, 32'({fb_xpos, fb_ypos, fb_din}), 32'd0);
    check_eq({tag, "_rmode"}, 32'(fb_r_mode), 32'd0);
    check_eq({tag, "_rdata"}, 32'({c1_rdata, c0_rdata}), 32'd0);
    check_eq({tag, "_gid"}, 32'(grant_id), 32'd0);
  endtask

  function automatic int rand_x();
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 255));
      1: return int'($urandom_range(117, 130));
      2: return 8 * int'($urandom_range(0, 16));
      default: return int'($urandom_range(0, 127));
    endcase
  endfunction

  function automatic int rand_y();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(52, 66));
    return int'($urandom_range(0, 70));
  endfunction

  initial begin
    rst = 1'b1;
    c0_req = 0; c0_wr = 0; c0_x = 0; c0_y = 0; c0_din = 0; c0_mode = 0;
    c1_req = 0; c1_x = 0; c1_y = 0; c1_mode = 0;
    fb_w_valid = 0; fb_r_valid = 0; fb_dout = 0;
    m_last = 1'b1;
    m_rd[0] = 8'd0;
    m_rd[1] = 8'd0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    // Simultaneous reads after reset: c0 first, then c1, then c0 again.
    set_c0(0, 8, 8, 0, 0);
    set_c1(0, 0, 0);
    serve_one(2, 8'h11, 0);
    check_eq("tie_c1_waiting", 32'(c1_req), 32'd1);
    serve_one(1, 8'h22, 0);
    set_c0(0, 16, 16, 0, 1);
    set_c1(8, 8, 0);
    serve_one(3, 8'h33, 0);
    serve_one(1, 8'h44, 0);

    // Write with completion two cycles after the enable rises.
    set_c0(1, 16, 5, 8'hA5, 0);
    serve_one(3, 8'h00, 0);

    // Column reads at the bottom edge.
    set_c1(3, 56, 1);
    serve_one(2, 8'h3C, 0);
    set_c1(3, 57, 1);
    serve_one(2, 8'h99, 0);

    // Unaligned write near the right edge, then the aligned limit.
    set_c0(1, 121, 0, 8'h5A, 0);
    serve_one(1, 8'h00, 0);
    set_c0(1, 120, 0, 8'hFF, 0);
    serve_one(1, 8'h00, 0);

    // Framebuffer never answers: timeout error.
    set_c0(0, 0, 0, 0, 0);
    serve_one(1000, 8'h77, 0);

    // Reset in the middle of a read.
    set_c0(0, 24, 10, 0, 0);
    repeat (3) @(negedge clk);
    check_eq("mid_busy", 32'(fb_re), 32'd1);
    rst = 1'b1;
    c0_req = 1'b0;
    @(negedge clk);
    check_reset_state("midrst");
    rst = 1'b0;
    m_last = 1'b1;
    m_rd[0] = 8'd0;
    m_rd[1] = 8'd0;
    @(negedge clk);
    check_idle_outputs("post_rst");
    set_c0(0, 32, 4, 0, 0);
    set_c1(40, 4, 1);
    serve_all();

    // Randomised traffic.
    for (int n = 0; n < 80; n++) begin
      bit a0, a1;
      a0 = ($urandom_range(0, 2) != 0);
      a1 = ($urandom_range(0, 2) != 0);
      if (!a0 && !a1) a0 = 1'b1;
      if (a0) set_c0($urandom_range(0, 1) == 1, rand_x(), rand_y(), int'($urandom_range(0, 255)),
                     $urandom_range(0, 1) == 1);
      if (a1) set_c1(rand_x(), rand_y(), $urandom_range(0, 1) == 1);
      serve_all();
      for (int j = int'($urandom_range(0, 2)); j > 0; j--) begin
        @(negedge clk);
        check_idle_outputs("idle");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
